// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped branch target buffer with 2-bit saturating
// direction counters. It feeds pre_pc / pred_taken to the fetch-stage PC mux.
// Lookup is purely combinational against registered state. Execute trains it
// through resolved-branch updates.
// Optional feature: define BTB_PERF_EN to build the lookup-hit and mispredict
// performance counters. Without it, perf_hits and perf_mispred read 32'h0.
module branch_target_buffer #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pre_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_all,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - 2 - IDX_W;

  typedef logic [31:0]      word_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [1:0]       ctr_t;

  // Table state
  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q    [ENTRIES];
  word_t              target_q [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];

  // Lookup side: instruction-aligned PC, so bits [1:0] are ignored
  idx_t f_idx;
  tag_t f_tag;
  logic f_hit;

  assign f_idx      = fetch_pc[IDX_W+1:2];
  assign f_tag      = fetch_pc[31:IDX_W+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken = f_hit && ctr_q[f_idx][1];
  assign pre_pc     = pred_taken ? target_q[f_idx] : 32'h0;

  // Update side: reads the pre-edge contents of the entry being trained
  idx_t u_idx;
  tag_t u_tag;
  logic u_hit;
  ctr_t u_ctr;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  // Low PC bits carry no information for an aligned-instruction table
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  ctr_t ctr_next;
  logic write_ctr;
  logic write_target;
  logic write_alloc;

  // Decode the resolved branch into per-field write enables and the next counter value
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    ctr_next     = u_ctr;
    write_ctr    = 1'b0;
    write_target = 1'b0;
    write_alloc  = 1'b0;
    if (upd_valid && !flush_all) begin
      if (u_hit) begin
        write_ctr = 1'b1;
        if (upd_taken) begin
          ctr_next     = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
          write_target = 1'b1;
        end else begin
          ctr_next = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
        end
      end else if (upd_taken) begin
        write_alloc  = 1'b1;
        write_ctr    = 1'b1;
        write_target = 1'b1;
        ctr_next     = 2'b10;
      end
    end
  end

  // Table state: async clear, flush drops valids only, otherwise apply the decoded write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the table is built from flops rather than a RAM macro, so it can be
      // cleared asynchronously. Counters start weakly not-taken.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (flush_all) begin
      // NOTE: non-blocking assignments keep all state updates ordered at the edge,
      // so same-cycle lookups see only the old contents.
      valid_q <= '0;
    end else begin
      if (write_alloc) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
      end
      if (write_ctr) begin
        ctr_q[u_idx] <= ctr_next;
      end
      if (write_target) begin
        target_q[u_idx] <= upd_target;
      end
    end
  end

`ifdef BTB_PERF_EN
  logic        u_mispred;
  logic [31:0] hits_q;
  logic [31:0] mispred_q;

  assign u_mispred = upd_valid && !flush_all && ((u_hit && u_ctr[1]) != upd_taken);

  // Performance counters: count hitting lookup cycles and mispredicted updates, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (f_hit) begin
        hits_q <= hits_q + 32'd1;
      end
      if (u_mispred) begin
        mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign perf_hits    = hits_q;
  assign perf_mispred = mispred_q;
`else
  assign perf_hits    = 32'h0;
  assign perf_mispred = 32'h0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: scoreboard bench for branch_target_buffer.
// A table-level reference model predicts every cycle's lookup and perf-counter
// outputs. A monitor on the falling edge pops those predictions and compares them.
// Build with BTB_PERF_EN defined to also check the performance counters.
module tb_branch_target_buffer;

  localparam int          ENTRIES = 64;
  localparam int unsigned NE      = ENTRIES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic [31:0] pre_pc;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        flush_all = 1'b0;
  logic [31:0] perf_hits;
  logic [31:0] perf_mispred;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_pc     (fetch_pc),
    .pre_pc       (pre_pc),
    .pred_taken   (pred_taken),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .flush_all    (flush_all),
    .perf_hits    (perf_hits),
    .perf_mispred (perf_mispred)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: one record per table slot, indexed and tagged by integer division
  typedef struct {
    bit          v;
    int unsigned tag;
    int unsigned tgt;
    int          ctr;
  } ent_t;

  ent_t        m [ENTRIES];
  logic [31:0] m_hits;
  logic [31:0] m_mis;

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 4) % NE;
  endfunction

  function automatic int unsigned m_tag(input int unsigned pc);
    return pc / (4 * NE);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m[m_idx(pc)].v && (m[m_idx(pc)].tag == m_tag(pc));
  endfunction

  function automatic bit m_pred(input int unsigned pc);
    return m_hit(pc) && (m[m_idx(pc)].ctr >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m[i].v   = 1'b0;
      m[i].tag = 0;
      m[i].tgt = 0;
      m[i].ctr = 1;
    end
    m_hits = '0;
    m_mis  = '0;
  endtask

  // Expected response queue
  typedef struct packed {
    logic        pt;
    logic [31:0] pc;
    logic [31:0] hits;
    logic [31:0] mis;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q [$];
  int   cyc_no = 0;

  // Drive one cycle of stimulus just after the rising edge and predict what the DUT shows
  task automatic cycle(input logic rs, input logic [31:0] fpc, input logic uv,
                       input logic [31:0] upc, input logic [31:0] utg,
                       input logic utk, input logic fl);
    exp_t        e;
    int unsigned ui;
    @(posedge clk);
    #1;
    reset      = rs;
    fetch_pc   = fpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_target = utg;
    upd_taken  = utk;
    flush_all  = fl;
    e          = '0;
    e.cyc      = cyc_no;
    cyc_no++;
    if (rs) begin
      model_reset();
    end else begin
      e.pt = m_pred(fpc);
      e.pc = e.pt ? m[m_idx(fpc)].tgt : 32'h0;
`ifdef BTB_PERF_EN
      e.hits = m_hits;
      e.mis  = m_mis;
`endif
      if (m_hit(fpc)) m_hits = m_hits + 1;
      if (uv && !fl && (m_pred(upc) != utk)) m_mis = m_mis + 1;
      ui = m_idx(upc);
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m[i].v = 1'b0;
      end else if (uv) begin
        if (m_hit(upc)) begin
          if (utk) begin
            m[ui].ctr = (m[ui].ctr < 3) ? m[ui].ctr + 1 : 3;
            m[ui].tgt = utg;
          end else begin
            m[ui].ctr = (m[ui].ctr > 0) ? m[ui].ctr - 1 : 0;
          end
        end else if (utk) begin
          m[ui].v   = 1'b1;
          m[ui].tag = m_tag(upc);
          m[ui].tgt = utg;
          m[ui].ctr = 2;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest prediction on each falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("pred_taken c%0d", e.cyc), {31'h0, pred_taken}, {31'h0, e.pt});
        check($sformatf("pre_pc c%0d", e.cyc), pre_pc, e.pc);
        check($sformatf("perf_hits c%0d", e.cyc), perf_hits, e.hits);
        check($sformatf("perf_mispred c%0d", e.cyc), perf_mispred, e.mis);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] PA = 32'h8000_0100;
  localparam logic [31:0] PB = 32'h8000_0200;  // aliases PA's index with a different tag
  localparam logic [31:0] PC = 32'h8000_0104;
  localparam logic [31:0] TA = 32'h8000_0200;

  initial begin
    logic [31:0] pool [8];
    logic [31:0] fpc;
    logic [31:0] upc;
    int          budget;
    pool[0] = PA;            pool[1] = PB;
    pool[2] = PC;            pool[3] = 32'h8000_1104;
    pool[4] = 32'h0000_0010; pool[5] = 32'h8000_0013;
    pool[6] = 32'h1234_5678; pool[7] = 32'h8000_0108;
    model_reset();

    // Reset holds outputs at zero
    cycle(1, PA, 0, 0, 0, 0, 0);
    cycle(1, PA, 1, PA, TA, 1, 0);
    // Cold lookup misses
    cycle(0, PA, 0, 0, 0, 0, 0);
    // Allocate: same-cycle lookup sees old contents, next cycle hits
    cycle(0, PA, 1, PA, TA, 1, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    // Two not-taken updates: 10 -> 01 -> 00
    cycle(0, PA, 1, PA, 32'h0, 0, 0);
    cycle(0, PA, 1, PA, 32'h0, 0, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    // Three taken updates to saturate, then one not-taken still predicts taken
    cycle(0, PA, 1, PA, TA, 1, 0);
    cycle(0, PA, 1, PA, TA, 1, 0);
    cycle(0, PA, 1, PA, TA, 1, 0);
    cycle(0, PA, 1, PA, TA, 0, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    // Alias: PB misses, a taken update replaces the entry, then PA misses
    cycle(0, PB, 0, 0, 0, 0, 0);
    cycle(0, PB, 1, PB, 32'h8000_0400, 1, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    cycle(0, PB, 0, 0, 0, 0, 0);
    // Flush beats a same-cycle taken update
    cycle(0, PB, 1, PC, 32'h8000_0800, 1, 1);
    cycle(0, PB, 0, 0, 0, 0, 0);
    cycle(0, PC, 0, 0, 0, 0, 0);
    // Retrain after flush: counters retained, update allocates again
    cycle(0, PC, 1, PA, TA, 1, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);

    // Randomized traffic over a small PC pool so hits and aliasing are frequent
    for (int n = 0; n < 1500; n++) begin
      fpc = pool[$urandom_range(0, 7)];
      upc = pool[$urandom_range(0, 7)];
      cycle(($urandom_range(0, 299) == 0), fpc, 1'($urandom_range(0, 1)), upc, $urandom,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end

    // Reset asserted with an update pending: the update is lost
    cycle(0, PA, 1, PA, TA, 1, 0);
    cycle(1, PA, 1, PC, 32'h8000_0900, 1, 0);
    cycle(0, PC, 0, 0, 0, 0, 0);
    cycle(0, PA, 0, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
